// File: rtl/dm163_receiver.sv
// DM163 serial receiver: sync pins, shift 192 bits, latch PWM/DC banks (DM163_RX_LEN_CHECK_EN adds len_err).
// Latency: SYNC_STAGES+1 clk from a pin edge to the register update and frame_stb.
// Backpressure: none; the serial master is never stalled and edges must meet the minimum phase width.
module dm163_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_sda,
  input  logic       s_clk,
  input  logic       s_rst,
  input  logic       lat,
  input  logic       sb,
  input  logic [4:0] rd_ch,
  output logic [7:0] rd_pwm,
  output logic [5:0] rd_dc,
  output logic       frame_stb,
  output logic       frame_bank,
  output logic [7:0] bit_cnt,
  output logic       len_err
);

  // Synchronizer lanes packed as {sb, lat, s_rst, s_clk, s_sda}; s_rst idles high.
  localparam logic [4:0] SYNC_RST = 5'b00100;

  logic [4:0]   sync_q [SYNC_STAGES];
  logic         sda_s, sclk_s, srst_n_s, lat_s, sb_s;
  logic         sclk_q, lat_q;
  logic         sclk_rise, lat_rise;
  logic [191:0] shift_q, shift_nxt;
  logic [7:0]   cnt_nxt;
  logic [7:0]   pwm_q [24];
  logic [5:0]   dc_q  [24];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {sb, lat, s_rst, s_clk, s_sda};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {sb_s, lat_s, srst_n_s, sclk_s, sda_s} = sync_q[SYNC_STAGES-1];

  // Edge registers keep tracking during s_rst so its release never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 1'b0;
      lat_q  <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      lat_q  <= lat_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_q & srst_n_s;
  assign lat_rise  = lat_s  & ~lat_q  & srst_n_s;

  // A latch coinciding with a shift captures the register including the new bit.
  assign shift_nxt = sclk_rise ? {shift_q[190:0], sda_s} : shift_q;
  assign cnt_nxt   = (sclk_rise && bit_cnt != 8'hFF) ? bit_cnt + 8'd1 : bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      frame_stb  <= 1'b0;
      frame_bank <= 1'b0;
      for (int k = 0; k < 24; k++) begin
        pwm_q[k] <= '0;
        dc_q[k]  <= '0;
      end
    end else begin
      frame_stb <= 1'b0;
      if (!srst_n_s) begin
        shift_q <= '0;
        bit_cnt <= '0;
      end else begin
        shift_q <= shift_nxt;
        bit_cnt <= cnt_nxt;
        if (lat_rise) begin
          frame_stb  <= 1'b1;
          frame_bank <= sb_s;
          bit_cnt    <= '0;
          for (int k = 0; k < 24; k++) begin
            if (sb_s) pwm_q[k] <= shift_nxt[8*k +: 8];
            else      dc_q[k]  <= shift_nxt[6*k +: 6];
          end
        end
      end
    end
  end

`ifdef DM163_RX_LEN_CHECK_EN
  logic len_bad;
  assign len_bad = sb_s ? (cnt_nxt != 8'd192) : (cnt_nxt != 8'd144);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       len_err <= 1'b0;
    else if (lat_rise && len_bad)  len_err <= 1'b1;
  end
`else
  assign len_err = 1'b0;
`endif

  always_comb begin
    rd_pwm = '0;
    rd_dc  = '0;
    if (rd_ch < 5'd24) begin
      rd_pwm = pwm_q[rd_ch];
      rd_dc  = dc_q[rd_ch];
    end
  end

endmodule

// File: tb/tb_dm163_receiver.sv
// Directed bench for dm163_receiver: frames, latches, s_rst, saturation, mid-frame reset.
// Outputs sampled 1 time unit after the rising clk edge; inputs driven at the same point.
module tb_dm163_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_sda = 1'b0, s_clk = 1'b0, s_rst = 1'b1, lat = 1'b0, sb = 1'b0;
  logic [4:0] rd_ch = '0;
  logic [7:0] rd_pwm;
  logic [5:0] rd_dc;
  logic       frame_stb, frame_bank;
  logic [7:0] bit_cnt;
  logic       len_err;

  int checks = 0;
  int failures = 0;
  int stb_cnt = 0;
  logic [191:0] f;
  logic exp_le;

  dm163_receiver #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .s_sda(s_sda), .s_clk(s_clk), .s_rst(s_rst),
    .lat(lat), .sb(sb), .rd_ch(rd_ch), .rd_pwm(rd_pwm), .rd_dc(rd_dc),
    .frame_stb(frame_stb), .frame_bank(frame_bank), .bit_cnt(bit_cnt),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_stb) stb_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sbit(input logic b);
    s_sda = b;
    cyc(4);
    s_clk = 1'b1;
    cyc(4);
    s_clk = 1'b0;
  endtask

  task automatic send(input logic [191:0] fr, input int n);
    for (int i = n - 1; i >= 0; i--) sbit(fr[i]);
    cyc(4);
  endtask

  task automatic send_const(input logic b, input int n);
    for (int i = 0; i < n; i++) sbit(b);
    cyc(4);
  endtask

  // Latch with exact-cycle check of the strobe: 3 clk after the pin edge.
  task automatic do_lat(input logic b);
    int s0;
    sb = b;
    cyc(4);
    s0 = stb_cnt;
    lat = 1'b1;
    cyc(2);
    chk("stb_before", {31'd0, frame_stb}, 32'd0);
    cyc(1);
    chk("stb_at_lat", {31'd0, frame_stb}, 32'd1);
    cyc(1);
    chk("stb_after", {31'd0, frame_stb}, 32'd0);
    cyc(3);
    lat = 1'b0;
    cyc(4);
    chk("stb_pulses", stb_cnt - s0, 32'd1);
    chk("frame_bank", {31'd0, frame_bank}, {31'd0, b});
    chk("bit_cnt_lat", {24'd0, bit_cnt}, 32'd0);
  endtask

  task automatic rd(input logic [4:0] ch, input logic [7:0] ep, input logic [5:0] ed, input string tag);
    rd_ch = ch;
    #1;
    chk({tag, "_pwm"}, {24'd0, rd_pwm}, {24'd0, ep});
    chk({tag, "_dc"},  {26'd0, rd_dc},  {26'd0, ed});
  endtask

  task automatic do_rst();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(4);
  endtask

  initial begin
`ifdef DM163_RX_LEN_CHECK_EN
    exp_le = 1'b1;
`else
    exp_le = 1'b0;
`endif
    cyc(3);
    rst = 1'b0;
    cyc(4);
    chk("rst_bit_cnt", {24'd0, bit_cnt}, 32'd0);
    chk("rst_stb", {31'd0, frame_stb}, 32'd0);
    chk("rst_bank", {31'd0, frame_bank}, 32'd0);
    chk("rst_len_err", {31'd0, len_err}, 32'd0);
    rd(5'd0, 8'h00, 6'h00, "rst_ch0");

    // ch23 = FF, all other channels zero
    f = '0;
    f[191:184] = 8'hFF;
    send(f, 192);
    chk("cnt_192", {24'd0, bit_cnt}, 32'd192);
    do_lat(1'b1);
    rd(5'd23, 8'hFF, 6'h00, "f1_ch23");
    rd(5'd0, 8'h00, 6'h00, "f1_ch0");
    chk("f1_len_err", {31'd0, len_err}, 32'd0);

    // channel mapping: ch k = 0x10 + k
    for (int k = 0; k < 24; k++) f[8*k +: 8] = 8'h10 + 8'(k);
    send(f, 192);
    do_lat(1'b1);
    rd(5'd5, 8'h15, 6'h00, "map_ch5");
    rd(5'd17, 8'h21, 6'h00, "map_ch17");
    rd(5'd23, 8'h27, 6'h00, "map_ch23");

    // dot-correction frame: ch0 = 2A, ch23 = 15
    f = '0;
    f[5:0] = 6'h2A;
    f[143:138] = 6'h15;
    send(f, 144);
    chk("cnt_144", {24'd0, bit_cnt}, 32'd144);
    do_lat(1'b0);
    rd(5'd0, 8'h10, 6'h2A, "dc_ch0");
    rd(5'd23, 8'h27, 6'h15, "dc_ch23");
    chk("dc_len_err", {31'd0, len_err}, 32'd0);

    // s_rst pulse clears partial frame; clocks while low are ignored
    send_const(1'b1, 50);
    chk("cnt_50", {24'd0, bit_cnt}, 32'd50);
    s_rst = 1'b0;
    cyc(4);
    send_const(1'b1, 3);
    s_rst = 1'b1;
    cyc(4);
    chk("srst_cnt", {24'd0, bit_cnt}, 32'd0);
    do_lat(1'b1);
    do_lat(1'b0);
    rd(5'd5, 8'h00, 6'h00, "srst_ch5");
    rd(5'd23, 8'h00, 6'h00, "srst_ch23");

    // short frame length error (sticky when the check is built in)
    do_rst();
    chk("rst2_len_err", {31'd0, len_err}, 32'd0);
    send_const(1'b1, 100);
    chk("cnt_100", {24'd0, bit_cnt}, 32'd100);
    do_lat(1'b1);
    chk("short_len_err", {31'd0, len_err}, {31'd0, exp_le});
    send_const(1'b0, 192);
    do_lat(1'b1);
    chk("sticky_len_err", {31'd0, len_err}, {31'd0, exp_le});
    do_rst();
    chk("rst3_len_err", {31'd0, len_err}, 32'd0);

    // bit counter saturation and out-of-range read
    send_const(1'b1, 300);
    chk("cnt_sat", {24'd0, bit_cnt}, 32'd255);
    do_lat(1'b1);
    do_lat(1'b0);
    rd(5'd23, 8'hFF, 6'h3F, "sat_ch23");
    rd(5'd24, 8'h00, 6'h00, "oob_ch24");
    rd(5'd31, 8'h00, 6'h00, "oob_ch31");

    // reset mid-frame, then a fresh frame ch k = k
    send_const(1'b1, 96);
    do_rst();
    chk("mid_rst_cnt", {24'd0, bit_cnt}, 32'd0);
    rd(5'd23, 8'h00, 6'h00, "mid_rst_ch23");
    for (int k = 0; k < 24; k++) f[8*k +: 8] = 8'(k);
    send(f, 192);
    chk("new_cnt", {24'd0, bit_cnt}, 32'd192);
    do_lat(1'b1);
    rd(5'd1, 8'h01, 6'h00, "new_ch1");
    rd(5'd12, 8'h0C, 6'h00, "new_ch12");
    rd(5'd23, 8'h17, 6'h00, "new_ch23");
    chk("new_len_err", {31'd0, len_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm163_receiver.md
DM163_RECEIVER -- requirements
Module: dm163_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth (at least 2) on every serial input.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port s_sda, input, 1 bit: serial data, asynchronous to clk.
REQ-005 SHALL have port s_clk, input, 1 bit: serial shift clock; data is taken on its rising edge; asynchronous to clk.
REQ-006 SHALL have port s_rst, input, 1 bit: DM163 reset, active-low, asynchronous to clk.
REQ-007 SHALL have port lat, input, 1 bit: latch strobe; acts on its rising edge.
REQ-008 SHALL have port sb, input, 1 bit: bank select; 1 = PWM bank (8 bit/ch), 0 = dot-correction bank (6 bit/ch).
REQ-009 SHALL have port rd_ch, input, 5 bits: channel index for the read port.
REQ-010 SHALL have port rd_pwm, output, 8 bits: PWM bank value of channel rd_ch, combinational.
REQ-011 SHALL have port rd_dc, output, 6 bits: dot-correction bank value of channel rd_ch, combinational.
REQ-012 SHALL have port frame_stb, output, 1 bit: one-cycle pulse on each latch event.
REQ-013 SHALL have port frame_bank, output, 1 bit: value of sb captured at the last latch.
REQ-014 SHALL have port bit_cnt, output, 8 bits: count of bits shifted since the last latch or s_rst.
REQ-015 SHALL have port len_err, output, 1 bit: sticky length-error flag.

Function
REQ-016 SHALL pass s_sda, s_clk, s_rst, lat and sb each through SYNC_STAGES flops before use, and detect rising edges of the synchronized s_clk and lat.
REQ-017 SHALL, on a detected s_clk rise, shift the synchronized s_sda into bit 0 of a 192-bit shift register (MSB first) and increment bit_cnt, saturating at 255.
REQ-018 SHALL, on a detected lat rise with sb=1, load PWM channel k from shift[8k+7:8k] for k = 0..23.
REQ-019 SHALL, on a detected lat rise with sb=0, load dot-correction channel k from shift[6k+5:6k] for k = 0..23; shift[191:144] are ignored.
REQ-020 SHALL, on a latch event: assert frame_stb for exactly one cycle, update frame_bank, clear bit_cnt, and leave the shift register unchanged.
REQ-021 SHALL, when an s_clk rise and a lat rise are detected in the same cycle, latch the shift value that includes the newly shifted bit; bit_cnt then reads 0.
REQ-022 SHALL have a latency of SYNC_STAGES+1 clk cycles from a pin edge to the register update, with frame_stb asserted in that same cycle.
REQ-023 SHALL, while the synchronized s_rst is low: clear the shift register and bit_cnt, ignore s_clk and lat, and leave both banks unchanged.
REQ-024 SHALL drive rd_pwm = 0 and rd_dc = 0 when rd_ch > 23.
REQ-025 SHALL be guaranteed correct only when s_clk and lat high and low phases are each at least SYNC_STAGES+1 clk periods; behaviour with shorter phases is undefined.

Reset
REQ-026 SHALL, while rst is high, clear: the shift register, both banks, the synchronizers and edge registers (synchronized s_rst resets to 1), bit_cnt, frame_stb, frame_bank and len_err.
REQ-027 SHALL, when rst is asserted mid-frame, discard the partial frame; the first s_clk rise after release shifts bit 0 of a new frame.

Configuration
REQ-028 SHALL, with DM163_RX_LEN_CHECK_EN defined, set len_err at a latch event when bit_cnt (before clearing) differs from 192 (sb=1) or 144 (sb=0); the banks still load, and len_err clears only on rst.
REQ-029 SHALL, without DM163_RX_LEN_CHECK_EN, tie len_err to 0 and include no comparison logic.

Verification
REQ-030 SHALL pass this scenario: rst; shift 192 bits with ch23=8'hFF and all others 0; lat with sb=1 -> rd_ch=23 gives rd_pwm=8'hFF, rd_ch=0 gives 0, one frame_stb, frame_bank=1, bit_cnt=0.
REQ-031 SHALL pass this scenario: shift 144 bits with ch0=6'h2A; lat with sb=0 -> rd_dc(0)=6'h2A, PWM bank unchanged, len_err=0.
REQ-032 SHALL pass this scenario (DM163_RX_LEN_CHECK_EN defined): shift 100 bits then lat with sb=1 -> len_err=1, which holds through a following correct frame until rst.
REQ-033 SHALL pass this scenario: shift 50 bits, pulse s_rst low, then lat -> bit_cnt is 0 after the s_rst pulse and the banks load all zeros.
REQ-034 SHALL pass this scenario: shift 300 bits -> bit_cnt=255; lat -> bit_cnt=0; rd_ch=31 gives rd_pwm=0 and rd_dc=0.
REQ-035 SHALL pass this scenario: assert rst after 96 bits, release, send a full 192-bit frame -> the banks reflect only the new frame.
